micro_mult_seq: RTL and testbench
=================================

// Module: micro_mult_seq
// PURPOSE
//  Parametrised sequential shift-add multiplier / multiply-accumulate unit; successor to the fixed 4x4 micro multiplier.
//  Generalised to WIDTH-bit operands with start/busy/done handshake, MAC mode with sticky overflow, optional signed mode.
//  Sits behind the top-level pin wrapper; operands arrive from ui_in, and product/acc slices drive uo_out.
// PARAMETERS
//  WIDTH  4           operand width in bits (>=2)
//  ACC_W  2*WIDTH+4   accumulator width (>=2*WIDTH); accumulator guard bits = ACC_W-2*WIDTH
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        begin operation; sampled only in IDLE
//  a            in   WIDTH    multiplicand, latched at accepted start
//  b            in   WIDTH    multiplier, latched at accepted start
//  mac          in   1        1 = add product into acc at completion; 0 = product only; latched at start
//  clr_acc      in   1        synchronous clear of acc and ovf; honoured in IDLE only
//  signed_mode  in   1        1 = two's-complement operands (needs MICRO_MULT_SIGNED_EN); latched at start
//  product      out  2*WIDTH  last product; held until the next completion
//  acc          out  ACC_W    running accumulator
//  busy         out  1        high from accepted start through the done cycle
//  done         out  1        single-cycle completion pulse
//  ovf          out  1        sticky accumulator overflow
// BEHAVIOUR
//  Reset: state=IDLE; product, acc, busy, done, ovf, internal counters and latches all 0.
//  FSM IDLE->RUN->DONE->IDLE.
//   IDLE: start=1 at edge E0 latches a, b, mac and signed_mode, clears the partial sum, sets count=WIDTH-1, enters RUN.
//   RUN: one multiplier bit per edge (LSB first); add the multiplicand if the bit is 1, then shift right.
//        Iterations run on E1..EW. At EW: product is registered, acc is updated if mac=1, state becomes DONE.
//   DONE: done=1 and busy=1 for exactly one cycle; at E(W+1) state returns to IDLE and busy=0.
//  Latency: done is visible WIDTH cycles after the start edge; throughput is one operation per WIDTH+2 cycles.
//  start while busy (RUN or DONE): ignored, not queued.
//  Operand or mode input changes after E0: no effect.
//  clr_acc in IDLE: acc=0 and ovf=0 at the next edge.
//  clr_acc together with start and mac=1: clear applies at E0; the completed op leaves acc equal to the product.
//  clr_acc in RUN or DONE: ignored.
//  Arithmetic: product is exact in 2*WIDTH bits.
//   MAC adds the product (zero-extended, or sign-extended when signed) into acc modulo 2^ACC_W.
//   ovf sets on unsigned carry-out (unsigned) or on signed overflow (signed); it stays set until clr_acc or reset.
//  Reset asserted mid-operation: immediate return to reset values; no done pulse; partial result discarded.
// CONFIGURATION
//  MICRO_MULT_SIGNED_EN defined:
//   signed_mode=1 sign-extends the multiplicand to 2*WIDTH+1 bits.
//   The final (MSB) iteration subtracts instead of adds; acc add and ovf use signed rules.
//  MICRO_MULT_SIGNED_EN undefined:
//   signed_mode is ignored (tied off internally); all operations are unsigned; no subtract path is synthesised.
// STRUCTURE
//  Package micro_mult_pkg holds:
//   state enum (IDLE, RUN, DONE), encoded in 2 bits;
//   localparam function clog2 for the counter width;
//   default ACC_W guard-bit constant (4).
//  One sub-module, micro_mult_addsub: (2*WIDTH+1)-bit add/subtract step with sub select.
//  FSM, counter, shift registers and accumulator stay in micro_mult_seq.
// TESTING (WIDTH=4, ACC_W=12 unless stated)
//  1. a=15, b=15, mac=0, start pulse -> done exactly 4 cycles after the start edge; product=0xE1; acc=0; busy low next cycle.
//  2. MAC sequence: clr_acc; then 3*5 and 2*4 with mac=1 -> acc=23 (0x017); ovf=0; product=0x08.
//  3. 19 MAC ops of 15*15 from acc=0 -> acc=4275 mod 4096=179 (0x0B3); ovf=1; then clr_acc -> acc=0, ovf=0.
//  4. Signed, macro defined: a=-8 (0x8), b=7, signed_mode=1 -> product=0xC8 (-56).
//     Same stimulus with the macro undefined -> product=0x38 (8*7).
//  5. start held high and operands changed during RUN -> single done pulse; result uses the E0 operands.
//     Next op accepted only after busy falls.
//  6. rst_n low two cycles after start -> busy=0, done=0, product=0, acc=0 asynchronously.
//     No done pulse follows. A fresh 6*7 op then gives product=0x2A.

Source files
------------

// File: rtl/micro_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | micro_mult_pkg : shared types and constants for micro_mult_seq        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package micro_mult_pkg;

  localparam int c_acc_guard = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_mult_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | micro_mult_addsub : one shift-add step, add or subtract on i_sub      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module micro_mult_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  input  logic         i_sub,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_sub ? (i_x - i_y) : (i_x + i_y);

endmodule
`default_nettype wire

// File: rtl/micro_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | micro_mult_seq : sequential shift-add multiplier / MAC, sticky ovf    |
// | Signed operands available when MICRO_MULT_SIGNED_EN is defined.       |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module micro_mult_seq
  import micro_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 2*WIDTH + c_acc_guard
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mac,
  input  logic               clr_acc,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] product,
  output logic [ACC_W-1:0]   acc,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  localparam int c_pw    = 2*WIDTH + 1;
  localparam int c_cnt_w = clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic [c_pw-1:0]    r_mcand;
  logic [c_pw-1:0]    r_psum;
  logic [c_pw-1:0]    w_addend;
  logic [c_pw-1:0]    w_sum;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_count;
  logic               r_mac;
  logic               r_signed;
  logic               w_signed_req;
  logic               w_last;
  logic               w_sub;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_acc_carry;
  logic               w_acc_ovf;

  assign w_last = (r_count == '0);

  // MSB of a two's-complement multiplier carries negative weight.
`ifdef MICRO_MULT_SIGNED_EN
  assign w_signed_req = signed_mode;
  assign w_sub        = r_signed & w_last;
`else
  assign w_signed_req = signed_mode & 1'b0;
  assign w_sub        = 1'b0;
`endif

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  micro_mult_addsub #(
    .N (c_pw)
  ) u_addsub (
    .i_x   (r_psum),
    .i_y   (w_addend),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Accumulator add uses the final-step sum so acc and product land on the same edge.
  always_comb begin
    if (r_signed) begin
      w_prod_ext = ACC_W'($signed(w_sum[2*WIDTH-1:0]));
    end else begin
      w_prod_ext = ACC_W'(w_sum[2*WIDTH-1:0]);
    end
    {w_acc_carry, w_acc_sum} = {1'b0, acc} + {1'b0, w_prod_ext};
    if (r_signed) begin
      w_acc_ovf = (acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                  (w_acc_sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      w_acc_ovf = w_acc_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_psum   <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_mac    <= 1'b0;
      r_signed <= 1'b0;
      product  <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mcand  <= {{(WIDTH+1){w_signed_req & a[WIDTH-1]}}, a};
        r_mplier <= b;
        r_mac    <= mac;
        r_signed <= w_signed_req;
        r_psum   <= '0;
        r_count  <= c_cnt_w'(WIDTH-1);
      end else if (r_state == RUN) begin
        r_psum   <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - c_cnt_w'(1);
        if (w_last) begin
          product <= w_sum[2*WIDTH-1:0];
          if (r_mac) begin
            acc <= w_acc_sum;
            ovf <= ovf | w_acc_ovf;
          end
        end
      end
      if ((r_state == IDLE) && clr_acc) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_mult_seq.sv
`default_nettype none
// Bench for micro_mult_seq: directed and random operations scored against
// an arithmetic reference model through an expected-result queue.
module tb_micro_mult_seq;

  localparam int W  = 4;
  localparam int AW = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           mac = 1'b0;
  logic           clr_acc = 1'b0;
  logic           signed_mode = 1'b0;
  logic [2*W-1:0] product;
  logic [AW-1:0]  acc;
  logic           busy;
  logic           done;
  logic           ovf;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [AW-1:0]  acc;
    logic           ovf;
    int             due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_acc = 0;
  logic m_ovf = 1'b0;
  bit   chk_after = 1'b0;

  micro_mult_seq #(
    .WIDTH (W),
    .ACC_W (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .mac         (mac),
    .clr_acc     (clr_acc),
    .signed_mode (signed_mode),
    .product     (product),
    .acc         (acc),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's effective signedness.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic im, input logic isg, input logic iclr,
                       output exp_t e);
    int pa, pb, p, s, sa;
    bit sg;
`ifdef MICRO_MULT_SIGNED_EN
    sg = isg;
`else
    sg = isg && 1'b0;
`endif
    pa = int'(ia);
    pb = int'(ib);
    if (sg && ia[W-1]) pa -= (1 << W);
    if (sg && ib[W-1]) pb -= (1 << W);
    p = pa * pb;
    if (iclr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    if (im) begin
      if (sg) begin
        sa = (m_acc >= (1 << (AW-1))) ? m_acc - (1 << AW) : m_acc;
        s  = sa + p;
        if (s > (1 << (AW-1)) - 1 || s < -(1 << (AW-1))) m_ovf = 1'b1;
      end else begin
        s = m_acc + p;
        if (s >= (1 << AW)) m_ovf = 1'b1;
      end
      m_acc = ((s % (1 << AW)) + (1 << AW)) % (1 << AW);
    end
    e.prod = (2*W)'(p);
    e.acc  = AW'(m_acc);
    e.ovf  = m_ovf;
    e.due  = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic im, input logic isg, input logic iclr);
    exp_t e;
    wait_idle();
    a = ia; b = ib; mac = im; signed_mode = isg; clr_acc = iclr;
    start = 1'b1;
    model(ia, ib, im, isg, iclr, e);
    e.due = cyc + 1 + W;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    clr_acc = 1'b0;
  endtask

  task automatic clr_only();
    wait_idle();
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b expected 0 and 0", q.size(), busy);
      q.delete();
    end
  endtask

  // Monitor: every done pulse is scored against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_after) begin
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_single_pulse", {31'd0, done}, 32'd0);
      chk_after = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = q.pop_front();
        chk("product", {24'd0, product}, {24'd0, e.prod});
        chk("acc", {20'd0, acc}, {20'd0, e.acc});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        chk("done_latency_cycle", cyc, e.due);
        chk("busy_with_done", {31'd0, busy}, 32'd1);
        chk_after = 1'b1;
      end
    end
  end

  initial begin
    #12;
    chk("reset_product", {24'd0, product}, 32'd0);
    chk("reset_acc", {20'd0, acc}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 15*15 product only
    do_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("t1_product", {24'd0, product}, 32'h0E1);
    chk("t1_acc", {20'd0, acc}, 32'd0);

    // clear with start, then two MACs
    do_op(4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    do_op(4'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t2_acc", {20'd0, acc}, 32'h017);
    chk("t2_ovf", {31'd0, ovf}, 32'd0);
    chk("t2_product", {24'd0, product}, 32'h08);

    // 19 MACs of 15*15 wrap the accumulator
    do_op(4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) do_op(4'd15, 4'd15, 1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t3_acc", {20'd0, acc}, 32'h0B3);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    clr_only();
    chk("t3_clr_acc", {20'd0, acc}, 32'd0);
    chk("t3_clr_ovf", {31'd0, ovf}, 32'd0);

    // -8 * 7 in signed mode
    do_op(4'h8, 4'd7, 1'b0, 1'b1, 1'b0);
    wait_drain();
`ifdef MICRO_MULT_SIGNED_EN
    chk("t4_signed_product", {24'd0, product}, 32'h0C8);
`else
    chk("t4_unsigned_product", {24'd0, product}, 32'h038);
`endif

    // start held and operands changed during the run
    begin
      exp_t e;
      wait_idle();
      a = 4'd9; b = 4'd11; mac = 1'b0; signed_mode = 1'b0; start = 1'b1;
      model(4'd9, 4'd11, 1'b0, 1'b0, 1'b0, e);
      e.due = cyc + 1 + W;
      q.push_back(e);
      @(posedge clk); #1;
      for (int i = 0; i <= W; i++) begin
        a = 4'($urandom);
        b = 4'($urandom);
        mac = 1'($urandom);
        signed_mode = 1'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("t5_busy_low_before_next", {31'd0, busy}, 32'd0);
      chk("t5_single_result_pending", q.size(), 32'd0);
    end
    do_op(4'd10, 4'd3, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // randomized mix of products, MACs and clears
    for (int i = 0; i < 25; i++) begin
      do_op(4'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 5) == 0));
    end
    wait_drain();

    // reset asserted mid-operation
    do_op(4'd5, 4'd5, 1'b1, 1'b0, 1'b1);
    wait_drain();
    wait_idle();
    a = 4'd3; b = 4'd5; mac = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_product", {24'd0, product}, 32'd0);
    chk("t6_rst_acc", {20'd0, acc}, 32'd0);
    chk("t6_rst_ovf", {31'd0, ovf}, 32'd0);
    m_acc = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2*W + 2) @(posedge clk);
    #1;
    chk("t6_idle_after_reset", {31'd0, busy}, 32'd0);
    do_op(4'd6, 4'd7, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("t6_fresh_product", {24'd0, product}, 32'h02A);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
